dram_store_unit: RTL and testbench
==================================

# dram_store_unit

Buffered, parametrised store path between the LSU and the data-memory write port. It accepts RISC-V stores (sb/sh/sw/sd) through a valid/ready handshake and queues them in a DEPTH-entry FIFO. Each store is converted into aligned write beats with a byte mask and lane-shifted data. A store that crosses an XLEN/8-byte boundary is split into two beats; the scalar write controller had neither buffering nor split handling.

## Interface
- XLEN, 32 — datapath width; legal values 32 or 64. B = XLEN/8 bytes per beat.
- DEPTH, 4 — store FIFO entries; power of two, ≥ 2.
- ADDR_W, 32 — address width.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- st_valid  in  1  LSU presents a store.
- st_ready  out  1  FIFO can accept; equals !full.
- st_addr  in  ADDR_W  byte address of the store.
- st_data  in  XLEN  store data, right-aligned (LSBs hold the value).
- st_type  in  4  one-hot {sd, sw, sh, sb}.
- mem_valid  out  1  a write beat is presented.
- mem_ready  in  1  memory accepts the beat.
- mem_addr  out  ADDR_W  beat address, aligned to B (low log2(B) bits zero).
- mem_wdata  out  XLEN  lane-shifted write data.
- mem_wmask  out  B  byte-enable mask.
- err  out  1  one-cycle pulse when an illegal store is discarded.
- empty  out  1  FIFO holds no entries and no beat is in flight.

## Operation
- Push: on st_valid && st_ready, write {st_addr, st_data, st_type} at wr_ptr, then increment wr_ptr modulo DEPTH. Both pointers carry one extra wrap bit for full/empty detection.
- st_ready is computed from registered occupancy only. A pop in the same cycle does not free a slot for that cycle's push.
- Head conversion:
  - off = addr[log2(B)-1:0].
  - size_mask is 1, 3, 15 or 255 for sb, sh, sw, sd.
  - full_mask (2B bits) = size_mask << off.
  - full_data (2·XLEN bits) = data << (8·off).
  - Only the low size bytes of st_data are used; higher bytes are ignored.
- Beat FSM states:
  - IDLE: FIFO empty.
  - LO: present the first beat.
    - mem_addr = addr & ~(B-1).
    - mem_wmask = full_mask[B-1:0].
    - mem_wdata = full_data[XLEN-1:0].
  - HI: present the second beat.
    - mem_addr = LO address + B, modulo 2^ADDR_W.
    - mem_wmask = full_mask[2B-1:B].
    - mem_wdata = full_data[2XLEN-1:XLEN].
- Transitions:
  - IDLE→LO when the FIFO is non-empty.
  - LO on mem_ready: go to HI if full_mask[2B-1:B] ≠ 0; otherwise pop, then go to LO if entries remain, else IDLE.
  - HI on mem_ready: pop, then go to LO if entries remain, else IDLE.
- Illegal st_type: zero-hot, multi-hot, or sd when XLEN=32.
  - The store is accepted into the FIFO normally.
  - At the head it is popped in one cycle with mem_valid=0 and err=1 for that cycle.
- mem_valid is 1 only in LO/HI with a legal head entry.
- While mem_valid && !mem_ready, mem_addr, mem_wdata and mem_wmask are held stable.
- Beats drain strictly in FIFO order. The HI beat of a store always precedes any beat of the next store.
- empty = (FIFO count == 0) && state == IDLE.

## Timing
- Reset (asynchronous, rst_n=0) values:
  - Pointers = 0, state = IDLE.
  - st_ready = 1, mem_valid = 0, err = 0, empty = 1.
  - mem_addr, mem_wdata, mem_wmask = 0.
- Reset mid-operation discards all queued entries and any half-issued split; no further beats are issued.
- Latency: a store accepted at edge N can present its beat with mem_valid=1 in cycle N+1 at the earliest. mem_* outputs are combinational from head entry + state.
- Throughput: one beat per cycle under continuous mem_ready. Aligned stores therefore drain at one per cycle and split stores at one per two cycles.
- Full: count == DEPTH drives st_ready=0, and the LSU must hold its store. Simultaneous push and pop at count == DEPTH-1 leaves count unchanged.
- Pointer wrap at DEPTH is seamless; order is preserved across wrap.
- Address wrap: an HI beat from addr 0xFFFF_FFFE (sw, XLEN=32) goes to 0x0000_0000.

## Test plan
- Byte lane, XLEN=32: sb addr 0x8000_0003, data 0x0000_00AB → one beat: addr 0x8000_0000, mask 4'b1000, wdata 0xAB00_0000; empty=1 afterwards.
- Split, XLEN=32: sw addr 0x8000_0006, data 0x1122_3344 → beat 1: addr 0x8000_0004, mask 4'b1100, wdata 0x3344_0000; beat 2: addr 0x8000_0008, mask 4'b0011, wdata 0x0000_1122.
- Full/backpressure, DEPTH=4: mem_ready=0, issue 5 sw stores → st_ready=0 after the 4th accept and the 5th is held with outputs stable; mem_ready=1 → 5 beats in issue order, with st_ready=1 from the cycle after the first pop.
- Illegal type: st_type 4'b0011 followed by a legal sh to 0x10 with data 0xBEEF → err pulses for 1 cycle with no beat; then a beat at addr 0x10, mask 4'b0011, wdata 0x0000_BEEF.
- XLEN=64 sd: addr 0x1004, data 0x0102_0304_0506_0708 → beat 1: addr 0x1000, mask 8'hF0, wdata 0x0506_0708_0000_0000; beat 2: addr 0x1008, mask 8'h0F, wdata 0x0000_0000_0102_0304.
- Reset mid-split: rst_n=0 while HI is waiting on mem_ready → mem_valid=0 immediately, and after release empty=1 with no residual beat.

Source files
------------

// File: rtl/dram_store_unit.sv
// Buffered store path: queues LSU stores in a small FIFO and turns each one
// into one or two aligned write beats (byte mask + lane-shifted data).
// A store whose bytes straddle a B-byte boundary is issued as a LO beat
// followed by a HI beat. Illegal store types are dropped with an err pulse.
module dram_store_unit #(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [XLEN-1:0]   st_data,
    input  logic [3:0]        st_type,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_wmask,
    output logic              err,
    output logic              empty
);
    localparam int B     = XLEN / 8;
    localparam int MW    = 2 * B;
    localparam int OFF_W = $clog2(B);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI} state_t;

    state_t state_reg, state_next;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W-1:0] count;
    logic             push, pop, remain;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [XLEN-1:0]   data_mem [DEPTH];
    logic [3:0]        type_mem [DEPTH];

    logic [ADDR_W-1:0] head_addr;
    logic [XLEN-1:0]   head_data;
    logic [3:0]        head_type;
    logic              head_legal;
    logic [OFF_W-1:0]  head_off;
    logic [MW-1:0]     size_mask;
    logic [MW-1:0]     full_mask;
    logic [XLEN-1:0]   data_masked;
    logic [2*XLEN-1:0] full_data;
    logic              hi_needed;
    logic [ADDR_W-1:0] lo_addr, hi_addr;

    // Occupancy comes from registered pointers only, so a pop never frees a
    // slot for the same cycle's push.
    assign count    = wr_ptr_reg - rd_ptr_reg;
    assign st_ready = (count != PTR_W'(DEPTH));
    assign push     = st_valid && st_ready;
    // Entries left after the current pop, counting a push landing this cycle.
    assign remain   = (count > PTR_W'(1)) || push;
    assign empty    = (count == '0) && (state_reg == S_IDLE);

    // Store payload written at the tail; contents need no reset because the
    // pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_reg[IDX_W-1:0]] <= st_addr;
            data_mem[wr_ptr_reg[IDX_W-1:0]] <= st_data;
            type_mem[wr_ptr_reg[IDX_W-1:0]] <= st_type;
        end
    end

    // Pointer advance on accepted push / completed pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        end
    end

    assign head_addr = addr_mem[rd_ptr_reg[IDX_W-1:0]];
    assign head_data = data_mem[rd_ptr_reg[IDX_W-1:0]];
    assign head_type = type_mem[rd_ptr_reg[IDX_W-1:0]];
    assign head_off  = head_addr[OFF_W-1:0];

    // sd only exists on a 64-bit datapath; anything not one-hot is illegal.
    assign head_legal = (head_type == 4'b0001) || (head_type == 4'b0010) ||
                        (head_type == 4'b0100) ||
                        ((XLEN == 64) && (head_type == 4'b1000));

    // Byte-enable pattern for the access size, before lane shifting.
    always_comb begin
        size_mask = '0;
        unique case (head_type)
            4'b0001: size_mask = MW'(8'h01);
            4'b0010: size_mask = MW'(8'h03);
            4'b0100: size_mask = MW'(8'h0F);
            4'b1000: size_mask = MW'(8'hFF);
            default: size_mask = '0;
        endcase
    end

    // Bytes above the access size are ignored rather than written.
    generate
        for (genvar gi = 0; gi < B; gi++) begin : g_byte_sel
            assign data_masked[8*gi +: 8] = size_mask[gi] ? head_data[8*gi +: 8] : 8'h00;
        end
    endgenerate

    assign full_mask = size_mask << head_off;
    assign full_data = {{XLEN{1'b0}}, data_masked} << {head_off, 3'b000};
    assign hi_needed = |full_mask[MW-1:B];
    assign lo_addr   = {head_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign hi_addr   = lo_addr + ADDR_W'(B);

    // Beat state register; reset drops any half-issued split immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= S_IDLE;
        else        state_reg <= state_next;
    end

    // Beat sequencing and write-port outputs (zero whenever no beat is shown).
    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        err        = 1'b0;
        mem_valid  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_wmask  = '0;
        unique case (state_reg)
            S_IDLE: begin
                // Entering LO on the push edge lets a beat show the next cycle.
                if (count != '0 || push) state_next = S_LO;
            end
            S_LO: begin
                if (!head_legal) begin
                    err        = 1'b1;
                    pop        = 1'b1;
                    state_next = remain ? S_LO : S_IDLE;
                end else begin
                    mem_valid = 1'b1;
                    mem_addr  = lo_addr;
                    mem_wdata = full_data[XLEN-1:0];
                    mem_wmask = full_mask[B-1:0];
                    if (mem_ready) begin
                        if (hi_needed) begin
                            state_next = S_HI;
                        end else begin
                            pop        = 1'b1;
                            state_next = remain ? S_LO : S_IDLE;
                        end
                    end
                end
            end
            S_HI: begin
                mem_valid = 1'b1;
                mem_addr  = hi_addr;
                mem_wdata = full_data[2*XLEN-1:XLEN];
                mem_wmask = full_mask[MW-1:B];
                if (mem_ready) begin
                    pop        = 1'b1;
                    state_next = remain ? S_LO : S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_dram_store_unit.sv
// Bench for dram_store_unit: a 32-bit and a 64-bit instance driven with
// directed and random stores; beats are collected by a monitor and compared
// with a byte-by-byte reference model.
module tb_dram_store_unit;
    typedef struct {
        bit          err;
        logic [31:0] addr;
        logic [63:0] data;
        logic [7:0]  mask;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        s32_valid = 0, s32_ready;
    logic [31:0] s32_addr = 0, s32_data = 0;
    logic [3:0]  s32_type = 0;
    logic        m32_valid, m32_ready, err32, e32;
    logic [31:0] m32_addr, m32_wdata;
    logic [3:0]  m32_wmask;

    logic        s64_valid = 0, s64_ready;
    logic [31:0] s64_addr = 0;
    logic [63:0] s64_data = 0;
    logic [3:0]  s64_type = 0;
    logic        m64_valid, m64_ready, err64, e64;
    logic [31:0] m64_addr;
    logic [63:0] m64_wdata;
    logic [7:0]  m64_wmask;

    logic rnd32 = 0, rnd64 = 0, forced32 = 1, forced64 = 1, rbit32 = 0, rbit64 = 0;
    assign m32_ready = rnd32 ? rbit32 : forced32;
    assign m64_ready = rnd64 ? rbit64 : forced64;

    int checks_total = 0;
    int checks_passed = 0;
    beat_t got32[$], got64[$], exp32[$], exp64[$];

    dram_store_unit #(.XLEN(32), .DEPTH(4), .ADDR_W(32)) u32 (
        .clk(clk), .rst_n(rst_n), .st_valid(s32_valid), .st_ready(s32_ready),
        .st_addr(s32_addr), .st_data(s32_data), .st_type(s32_type),
        .mem_valid(m32_valid), .mem_ready(m32_ready), .mem_addr(m32_addr),
        .mem_wdata(m32_wdata), .mem_wmask(m32_wmask), .err(err32), .empty(e32));

    dram_store_unit #(.XLEN(64), .DEPTH(4), .ADDR_W(32)) u64 (
        .clk(clk), .rst_n(rst_n), .st_valid(s64_valid), .st_ready(s64_ready),
        .st_addr(s64_addr), .st_data(s64_data), .st_type(s64_type),
        .mem_valid(m64_valid), .mem_ready(m64_ready), .mem_addr(m64_addr),
        .mem_wdata(m64_wdata), .mem_wmask(m64_wmask), .err(err64), .empty(e64));

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            rbit32 = 1'($urandom_range(0, 1));
            rbit64 = 1'($urandom_range(0, 1));
        end
    end

    // Record every accepted beat and every err pulse, sampled mid-cycle.
    always @(negedge clk) begin
        beat_t b;
        if (rst_n) begin
            if (m32_valid && m32_ready) begin
                b.err = 0; b.addr = m32_addr; b.data = {32'h0, m32_wdata}; b.mask = {4'h0, m32_wmask};
                got32.push_back(b);
            end
            if (err32) begin
                b.err = 1; b.addr = 0; b.data = 0; b.mask = 0;
                got32.push_back(b);
            end
            if (m64_valid && m64_ready) begin
                b.err = 0; b.addr = m64_addr; b.data = m64_wdata; b.mask = m64_wmask;
                got64.push_back(b);
            end
            if (err64) begin
                b.err = 1; b.addr = 0; b.data = 0; b.mask = 0;
                got64.push_back(b);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: place each stored byte at its own address, then group by beat.
    task automatic model(input bit is64, input logic [31:0] a, input logic [63:0] d, input logic [3:0] t);
        int nb = is64 ? 8 : 4;
        int size;
        int lane;
        logic [31:0] ba;
        beat_t b0, b1;
        bit legal = (t == 4'b0001) || (t == 4'b0010) || (t == 4'b0100) || (is64 && t == 4'b1000);
        b0.err = 0; b0.addr = a & ~32'(nb - 1); b0.data = 0; b0.mask = 0;
        b1.err = 0; b1.addr = b0.addr + 32'(nb); b1.data = 0; b1.mask = 0;
        if (!legal) begin
            b0.err = 1; b0.addr = 0;
            if (is64) exp64.push_back(b0); else exp32.push_back(b0);
        end else begin
            size = (t == 4'b0001) ? 1 : (t == 4'b0010) ? 2 : (t == 4'b0100) ? 4 : 8;
            for (int i = 0; i < size; i++) begin
                ba = a + 32'(i);
                lane = int'(ba % 32'(nb));
                if ((ba & ~32'(nb - 1)) == b0.addr) begin
                    b0.mask[lane] = 1'b1;
                    b0.data[8*lane +: 8] = d[8*i +: 8];
                end else begin
                    b1.mask[lane] = 1'b1;
                    b1.data[8*lane +: 8] = d[8*i +: 8];
                end
            end
            if (is64) exp64.push_back(b0); else exp32.push_back(b0);
            if (b1.mask != 0) begin
                if (is64) exp64.push_back(b1); else exp32.push_back(b1);
            end
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input bit is64, input logic [31:0] a, input logic [63:0] d, input logic [3:0] t);
        int n = 0;
        if (is64) begin s64_addr = a; s64_data = d; s64_type = t; s64_valid = 1; end
        else begin s32_addr = a; s32_data = d[31:0]; s32_type = t; s32_valid = 1; end
        while (!(is64 ? s64_ready : s32_ready) && n < 300) begin
            @(posedge clk); #1; n++;
        end
        chk(is64 ? "u64 send ready" : "u32 send ready", is64 ? s64_ready : s32_ready, 1);
        @(posedge clk); #1;
        if (is64) s64_valid = 0; else s32_valid = 0;
        model(is64, a, d, t);
    endtask

    task automatic wait_empty(input bit is64);
        int n = 0;
        while (!(is64 ? e64 : e32) && n < 500) begin
            @(posedge clk); #1; n++;
        end
        chk(is64 ? "u64 drained empty" : "u32 drained empty", is64 ? e64 : e32, 1);
    endtask

    task automatic compare(input bit is64);
        beat_t g[$], e[$];
        int n;
        if (is64) begin g = got64; e = exp64; got64.delete(); exp64.delete(); end
        else begin g = got32; e = exp32; got32.delete(); exp32.delete(); end
        chk($sformatf("u%0d beat count", is64 ? 64 : 32), g.size(), e.size());
        n = (g.size() < e.size()) ? g.size() : e.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("u%0d beat%0d err", is64 ? 64 : 32, i), g[i].err, e[i].err);
            chk($sformatf("u%0d beat%0d addr", is64 ? 64 : 32, i), g[i].addr, e[i].addr);
            chk($sformatf("u%0d beat%0d data", is64 ? 64 : 32, i), g[i].data, e[i].data);
            chk($sformatf("u%0d beat%0d mask", is64 ? 64 : 32, i), g[i].mask, e[i].mask);
        end
    endtask

    initial begin
        logic [31:0] ha, hd;
        logic [3:0]  hm, t;
        // Reset values
        #3;
        chk("rst st_ready", s32_ready, 1);
        chk("rst mem_valid", m32_valid, 0);
        chk("rst err", err32, 0);
        chk("rst empty", e32, 1);
        chk("rst mem_addr", m32_addr, 0);
        chk("rst mem_wdata", m32_wdata, 0);
        chk("rst mem_wmask", m32_wmask, 0);
        chk("rst u64 empty", e64, 1);
        chk("rst u64 mem_valid", m64_valid, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;

        // Byte lane
        send(0, 32'h8000_0003, 64'hAB, 4'b0001);
        wait_empty(0);
        chk("sb addr", got32[0].addr, 32'h8000_0000);
        chk("sb mask", got32[0].mask, 8'h08);
        chk("sb wdata", got32[0].data, 64'hAB00_0000);
        compare(0);

        // Split store
        send(0, 32'h8000_0006, 64'h1122_3344, 4'b0100);
        wait_empty(0);
        chk("split lo addr", got32[0].addr, 32'h8000_0004);
        chk("split lo mask", got32[0].mask, 8'h0C);
        chk("split lo wdata", got32[0].data, 64'h3344_0000);
        chk("split hi addr", got32[1].addr, 32'h8000_0008);
        chk("split hi mask", got32[1].mask, 8'h03);
        chk("split hi wdata", got32[1].data, 64'h0000_1122);
        compare(0);

        // Address wrap on the HI beat
        send(0, 32'hFFFF_FFFE, 64'hCAFE_BABE, 4'b0100);
        wait_empty(0);
        chk("wrap hi addr", got32[1].addr, 32'h0);
        compare(0);

        // Illegal type followed by a legal sh
        send(0, 32'h20, 64'h1234, 4'b0011);
        send(0, 32'h10, 64'hBEEF, 4'b0010);
        wait_empty(0);
        chk("illegal err", got32[0].err, 1);
        chk("after illegal addr", got32[1].addr, 32'h10);
        chk("after illegal mask", got32[1].mask, 8'h03);
        chk("after illegal wdata", got32[1].data, 64'hBEEF);
        compare(0);

        // 64-bit sd split
        send(1, 32'h1004, 64'h0102_0304_0506_0708, 4'b1000);
        wait_empty(1);
        chk("sd lo addr", got64[0].addr, 32'h1000);
        chk("sd lo mask", got64[0].mask, 8'hF0);
        chk("sd lo wdata", got64[0].data, 64'h0506_0708_0000_0000);
        chk("sd hi addr", got64[1].addr, 32'h1008);
        chk("sd hi mask", got64[1].mask, 8'h0F);
        chk("sd hi wdata", got64[1].data, 64'h0000_0000_0102_0304);
        compare(1);

        // Full FIFO with backpressure
        forced32 = 0;
        for (int i = 0; i < 4; i++) send(0, 32'h100 + 32'(4 * i), 64'($urandom), 4'b0100);
        chk("full st_ready", s32_ready, 0);
        ha = m32_addr; hd = m32_wdata; hm = m32_wmask;
        chk("held first addr", ha, 32'h100);
        s32_addr = 32'h110; s32_data = 32'h5555_AAAA; s32_type = 4'b0100; s32_valid = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("held st_ready", s32_ready, 0);
            chk("held mem_valid", m32_valid, 1);
            chk("held addr", m32_addr, ha);
            chk("held wdata", m32_wdata, hd);
            chk("held wmask", m32_wmask, hm);
        end
        forced32 = 1;
        @(posedge clk); #1;
        chk("ready after first pop", s32_ready, 1);
        @(posedge clk); #1;
        s32_valid = 0;
        model(0, 32'h110, 64'h5555_AAAA, 4'b0100);
        wait_empty(0);
        compare(0);

        // Reset while a HI beat waits
        forced32 = 0;
        send(0, 32'h8000_0006, 64'h1122_3344, 4'b0100);
        forced32 = 1;
        @(posedge clk); #1;
        forced32 = 0;
        chk("hi waiting valid", m32_valid, 1);
        chk("hi waiting addr", m32_addr, 32'h8000_0008);
        rst_n = 0;
        #1;
        chk("mid reset mem_valid", m32_valid, 0);
        got32.delete(); exp32.delete();
        @(posedge clk); #1;
        rst_n = 1; forced32 = 1;
        repeat (4) begin @(posedge clk); #1; end
        chk("post reset empty", e32, 1);
        chk("post reset residual beats", got32.size(), 0);

        // Random stores on both widths with random backpressure
        for (int w = 0; w < 2; w++) begin
            if (w == 0) rnd32 = 1; else rnd64 = 1;
            for (int i = 0; i < 30; i++) begin
                int r = int'($urandom_range(0, 9));
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                t = (r < 8) ? 4'(1 << (r % 4)) : 4'($urandom_range(0, 15));
                send(w == 1, $urandom, {$urandom, $urandom}, t);
            end
            rnd32 = 0; rnd64 = 0;
            wait_empty(w == 1);
            compare(w == 1);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
